// File: rtl/video_binarize_linebuf.sv
// Crops a we x he window out of the grey pixel stream, thresholds it to 1-bit,
// and emits each completed row alongside the previous row and its row index.
//
// state   | meaning
// WAIT_VS | idle after reset, waiting for the first frame sync rising edge
// FRAME   | counting source pixels/rows, capturing window pixels
// DONE    | last window row emitted, ignoring pixels until next frame sync
module video_binarize_linebuf #(
  parameter int DATA_WIDTH = 8,
  parameter int we         = 180,
  parameter int he         = 240,
  parameter int X_START    = 0,
  parameter int Y_START    = 0,
  parameter int THRESH     = 128
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  vs_in,
  input  logic                  de_in,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic [we-1:0]         line1,
  output logic [we-1:0]         line2,
  output logic [DATA_WIDTH-1:0] h,
  output logic                  line_clk,
  output logic                  frame_done,
  output logic                  line_err
);

  typedef enum logic [1:0] {WAIT_VS, FRAME, DONE} state_t;

  localparam int CW = (we > 1) ? $clog2(we) : 1;
  localparam logic [10:0] X_LO    = 11'(X_START);
  localparam logic [10:0] Y_LO    = 11'(Y_START);
  localparam logic [10:0] X_W     = 11'(we);
  localparam logic [10:0] Y_H     = 11'(he);
  localparam logic [10:0] X_END   = 11'(X_START + we);
  localparam logic [10:0] CNT_MAX = 11'h7ff;
  localparam logic [DATA_WIDTH-1:0] TH     = DATA_WIDTH'(THRESH);
  localparam logic [DATA_WIDTH-1:0] H_LAST = DATA_WIDTH'(he - 1);

  state_t state, state_nx;
  logic vs_d, de_d;
  logic [10:0] x_cnt, y_cnt, x_off, y_off;
  logic [we-1:0] row_buf, row_full;
  logic [CW-1:0] col;
  logic [DATA_WIDTH-1:0] row_h;
  logic vs_rise, de_fall, in_rows, in_cols, capture, emit, trunc, last_row;

  always_comb begin
    vs_rise  = vs_in & ~vs_d;
    de_fall  = de_d & ~de_in;
    // offsets wrap to large values left of / above the window, so one compare suffices
    x_off    = x_cnt - X_LO;
    y_off    = y_cnt - Y_LO;
    in_rows  = (y_off < Y_H);
    in_cols  = (x_off < X_W);
    capture  = (state == FRAME) && de_in && in_rows && in_cols;
    emit     = capture && (x_off == X_W - 11'd1);
    last_row = (y_off == Y_H - 11'd1);
    trunc    = (state == FRAME) && !vs_rise && de_fall && in_rows && (x_cnt < X_END);
    col      = CW'(x_off);
    row_h    = DATA_WIDTH'(y_off);
    row_full = row_buf;
    if (capture) row_full[col] = (pix_in >= TH);
  end

  always_comb begin
    state_nx = state;
    if (vs_rise)
      state_nx = FRAME;
    else if (emit && last_row)
      state_nx = DONE;
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_VS;
      vs_d    <= 1'b0;
      de_d    <= 1'b0;
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_buf <= '1;
    end else begin
      state <= state_nx;
      vs_d  <= vs_in;
      de_d  <= de_in;
      if (vs_rise) begin
        x_cnt   <= '0;
        y_cnt   <= '0;
        row_buf <= '1;
      end else if (state == FRAME) begin
        if (de_in && x_cnt != CNT_MAX) x_cnt <= x_cnt + 11'd1;
        if (capture) row_buf <= row_full;
        if (de_fall) begin
          x_cnt   <= '0;
          row_buf <= '1;
          if (y_cnt != CNT_MAX) y_cnt <= y_cnt + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      line1      <= '1;
      line2      <= '1;
      h          <= '0;
      line_clk   <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      line_clk   <= emit;
      line_err   <= trunc;
      frame_done <= line_clk && (h == H_LAST);
      if (emit) begin
        line1 <= row_full;
        // row 0 must not inherit the previous frame's last row
        line2 <= (y_off == 11'd0) ? '1 : line1;
        h     <= row_h;
      end
    end
  end

endmodule

// File: tb/tb_video_binarize_linebuf.sv
// Directed bench for video_binarize_linebuf: full default frame, truncated row,
// mid-frame restart, reset mid-row, and an offset small-window instance.
module tb_video_binarize_linebuf;
  localparam int W  = 180;
  localparam int WB = 16;
  localparam int HB = 8;

  logic video_clk = 1'b0;
  logic rst;
  always #5 video_clk = ~video_clk;

  logic vs_a, de_a;
  logic [7:0] pix_a;
  logic [W-1:0] l1_a, l2_a;
  logic [7:0] h_a;
  logic lc_a, fd_a, le_a;

  logic vs_b, de_b;
  logic [7:0] pix_b;
  logic [WB-1:0] l1_b, l2_b;
  logic [7:0] h_b;
  logic lc_b, fd_b, le_b;

  video_binarize_linebuf dut_a (
    .video_clk(video_clk), .rst(rst), .vs_in(vs_a), .de_in(de_a), .pix_in(pix_a),
    .line1(l1_a), .line2(l2_a), .h(h_a), .line_clk(lc_a), .frame_done(fd_a), .line_err(le_a)
  );

  video_binarize_linebuf #(.we(WB), .he(HB), .X_START(10), .Y_START(20)) dut_b (
    .video_clk(video_clk), .rst(rst), .vs_in(vs_b), .de_in(de_b), .pix_in(pix_b),
    .line1(l1_b), .line2(l2_b), .h(h_b), .line_clk(lc_b), .frame_done(fd_b), .line_err(le_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge video_clk) cyc++;

  logic [W-1:0] a_l1 [0:511];
  logic [W-1:0] a_l2 [0:511];
  int a_h [0:511];
  int a_lc_cyc [0:511];
  int a_ns = 0, a_fd = 0, a_le = 0, a_fd_cyc = 0;

  logic [WB-1:0] b_l1 [0:63];
  int b_h [0:63];
  int b_row [0:63];
  int b_ns = 0, b_fd = 0;
  int cur_row_b = 0;

  always @(negedge video_clk) begin
    if (lc_a) begin
      if (a_ns < 512) begin
        a_l1[a_ns] = l1_a; a_l2[a_ns] = l2_a; a_h[a_ns] = int'(h_a); a_lc_cyc[a_ns] = cyc;
      end
      a_ns++;
    end
    if (fd_a) begin a_fd++; a_fd_cyc = cyc; end
    if (le_a) a_le++;
    if (lc_b) begin
      if (b_ns < 64) begin
        b_l1[b_ns] = l1_b; b_h[b_ns] = int'(h_b); b_row[b_ns] = cur_row_b;
      end
      b_ns++;
    end
    if (fd_b) b_fd++;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Source pixel for DUT A; fr selects which directed frame is being driven.
  function automatic logic [7:0] pa(input int fr, input int row, input int c);
    if (fr == 1 && row == 5) return (c >= 60 && c <= 119) ? 8'd0 : 8'd255;
    if (fr == 1 && row == 3 && c <= 2) return 8'd127 + 8'(c);
    if (fr == 2 && row == 6 && c < 10) return 8'd0;
    if (fr == 3 && row == 0 && c < 4) return 8'd0;
    if (fr == 3 && row == 1 && c >= 176) return 8'd0;
    return 8'd200;
  endfunction

  function automatic logic [W-1:0] ea(input int fr, input int row);
    logic [W-1:0] r;
    for (int c = 0; c < W; c++) r[c] = (pa(fr, row, c) >= 8'd128);
    return r;
  endfunction

  function automatic logic [WB-1:0] eb(input int wrow);
    logic [WB-1:0] r;
    for (int c = 0; c < WB; c++) r[c] = (((c + 10) + (wrow + 20)) % 3 == 0);
    return r;
  endfunction

  task automatic vs_pulse_a();
    @(negedge video_clk); vs_a = 1'b1;
    repeat (3) @(negedge video_clk);
    vs_a = 1'b0;
    repeat (4) @(negedge video_clk);
  endtask

  task automatic line_a(input int fr, input int row, input int npix);
    for (int c = 0; c < npix; c++) begin
      @(negedge video_clk); de_a = 1'b1; pix_a = pa(fr, row, c);
    end
    @(negedge video_clk); de_a = 1'b0; pix_a = 8'd0;
    repeat (9) @(negedge video_clk);
  endtask

  task automatic line_b(input int row);
    cur_row_b = row;
    for (int c = 0; c < 40; c++) begin
      @(negedge video_clk); de_b = 1'b1;
      pix_b = ((row + c) % 3 == 0) ? 8'd200 : 8'd50;
    end
    @(negedge video_clk); de_b = 1'b0; pix_b = 8'd0;
    repeat (19) @(negedge video_clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] l1_row5;
    int b0, b1, fd0, le0, n0, bad_h, bad_l1;
    ones = '1;
    rst = 1'b1; vs_a = 1'b0; de_a = 1'b0; pix_a = '0;
    vs_b = 1'b0; de_b = 1'b0; pix_b = '0;
    repeat (3) @(negedge video_clk);
    chk("rst_line1", l1_a, ones);
    chk("rst_line2", l2_a, ones);
    chk("rst_h", W'(h_a), 0);
    chk("rst_strobes", W'({lc_a, fd_a, le_a}), 0);
    rst = 1'b0;
    repeat (3) @(negedge video_clk);

    // Frame 1: full 240 x 180 frame, special rows 3 and 5
    b0 = a_ns; fd0 = a_fd; le0 = a_le;
    vs_pulse_a();
    for (int r = 0; r < 240; r++) line_a(1, r, 180);
    repeat (5) @(negedge video_clk);
    chk("f1_strobes", W'(a_ns - b0), 240);
    bad_h = 0; bad_l1 = 0;
    for (int i = 0; i < 240; i++) begin
      if (a_h[b0+i] != i) bad_h++;
      if (a_l1[b0+i] !== ea(1, i)) bad_l1++;
    end
    chk("f1_h_order", W'(bad_h), 0);
    chk("f1_line1_all", W'(bad_l1), 0);
    chk("f1_white_row", a_l1[b0+100], ones);
    l1_row5 = a_l1[b0+5];
    chk("r5_bit59", W'(l1_row5[59]), 1);
    chk("r5_bit60", W'(l1_row5[60]), 0);
    chk("r5_bit119", W'(l1_row5[119]), 0);
    chk("r5_bit120", W'(l1_row5[120]), 1);
    chk("r6_line2", a_l2[b0+6], ea(1, 5));
    chk("thresh_bits", W'(a_l1[b0+3][2:0]), W'(3'b110));
    chk("f1_line2_h0", a_l2[b0], ones);
    chk("f1_done_cnt", W'(a_fd - fd0), 1);
    chk("f1_done_lat", W'(a_fd_cyc - a_lc_cyc[b0+239]), 1);
    chk("f1_no_err", W'(a_le - le0), 0);

    // Frame 2: truncated row 7, then vs_rise during row 50
    b1 = a_ns; fd0 = a_fd; le0 = a_le;
    vs_pulse_a();
    for (int r = 0; r < 7; r++) line_a(2, r, 180);
    line_a(2, 7, 100);
    for (int r = 8; r < 50; r++) line_a(2, r, 180);
    for (int c = 0; c < 30; c++) begin
      @(negedge video_clk); de_a = 1'b1; pix_a = 8'd200;
    end
    @(negedge video_clk); de_a = 1'b0; vs_a = 1'b1;
    repeat (3) @(negedge video_clk);
    vs_a = 1'b0;
    repeat (10) @(negedge video_clk);
    chk("f2_strobes", W'(a_ns - b1), 49);
    chk("f2_line_err", W'(a_le - le0), 1);
    chk("f2_no_done", W'(a_fd - fd0), 0);
    chk("f2_h6", W'(a_h[b1+6]), 6);
    chk("f2_h_after_trunc", W'(a_h[b1+7]), 8);
    chk("f2_l2_after_trunc", a_l2[b1+7], ea(2, 6));
    chk("f2_l1_after_trunc", a_l1[b1+7], ones);

    // Frame 3 continues after the mid-row restart
    line_a(3, 0, 180);
    line_a(3, 1, 180);
    chk("f3_strobes", W'(a_ns - b1), 51);
    chk("f3_h0", W'(a_h[b1+49]), 0);
    chk("f3_l2_h0", a_l2[b1+49], ones);
    chk("f3_l1_low", W'(a_l1[b1+49][4:0]), W'(5'b10000));
    chk("f3_l1_h1", a_l1[b1+50], ea(3, 1));
    chk("f3_l2_h1", a_l2[b1+50], ea(3, 0));

    // Reset in the middle of row 2, then a full row with no frame sync
    for (int c = 0; c < 50; c++) begin
      @(negedge video_clk); de_a = 1'b1; pix_a = 8'd10;
    end
    rst = 1'b1;
    @(negedge video_clk);
    chk("mid_rst_line1", l1_a, ones);
    chk("mid_rst_line2", l2_a, ones);
    chk("mid_rst_h", W'(h_a), 0);
    de_a = 1'b0;
    @(negedge video_clk); rst = 1'b0;
    n0 = a_ns;
    line_a(3, 2, 180);
    chk("post_rst_no_strobe", W'(a_ns - n0), 0);

    // Offset small window on the second instance
    @(negedge video_clk); vs_b = 1'b1;
    repeat (3) @(negedge video_clk);
    vs_b = 1'b0;
    repeat (4) @(negedge video_clk);
    for (int r = 0; r < 40; r++) line_b(r);
    repeat (5) @(negedge video_clk);
    chk("b_strobes", W'(b_ns), HB);
    chk("b_first_src_row", W'(b_row[0]), 20);
    chk("b_first_h", W'(b_h[0]), 0);
    chk("b_first_bits", W'(b_l1[0][3:0]), W'(4'b1001));
    bad_h = 0; bad_l1 = 0;
    for (int i = 0; i < HB; i++) begin
      if (b_h[i] != i) bad_h++;
      if (b_l1[i] !== eb(i)) bad_l1++;
    end
    chk("b_h_order", W'(bad_h), 0);
    chk("b_line1_all", W'(bad_l1), 0);
    chk("b_done", W'(b_fd), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
